// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: self-scanning multiplexed 7-segment display controller.
// A binary value is converted to BCD by a sequential double-dabble engine,
// leading zeros are blanked, and an optional "L-" label occupies the two
// leftmost digits. Digit 0 is the rightmost digit. The last committed image is
// shown unchanged while a conversion runs.
// Handshake: load is a request and is accepted only on a rising edge where
// busy=0. value and label_en are sampled on that edge. busy stays high from the
// next cycle until the new image has been committed (VAL_W+1 cycles). A load
// while busy is dropped, not queued.
// Optional feature: define SEG_BLINK_EN to add the blink input. With it, AN is
// forced off on alternate 64-frame periods whenever blink is high.
module seg_scan_ctrl #(
    parameter int DIGITS  = 4,
    parameter int VAL_W   = 8,
    parameter int CLK_DIV = 50000
) (
    input  logic              clk,
    input  logic              rst,
`ifdef SEG_BLINK_EN
    input  logic              blink,
`endif
    input  logic              load,
    input  logic [VAL_W-1:0]  value,
    input  logic              label_en,
    output logic              busy,
    output logic [DIGITS-1:0] AN,
    output logic [7:0]        SEGMENT,
    output logic [1:0]        dbg_state_o
);

    localparam int BCD_D = (VAL_W * 3) / 10 + 1;
    localparam int BW    = BCD_D * 4;
    localparam int NP    = (DIGITS > BCD_D) ? DIGITS : BCD_D;
    localparam int PW    = $clog2(CLK_DIV);
    localparam int IW    = $clog2(DIGITS);
    localparam int CW    = $clog2(VAL_W);
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX   = IW'(DIGITS - 1);
    localparam logic [CW-1:0] CNT_MAX   = CW'(VAL_W - 1);
    // Reset image: '0' on digit 0, every other digit blank.
    localparam logic [DIGITS*8-1:0] RST_IMG = {{(DIGITS-1){8'hFF}}, 8'hC0};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CONV   = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [VAL_W-1:0]         sh_q, sh_d;
    logic [BW-1:0]            bcd_q, bcd_d, bcd_adj;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic                     lbl_q, lbl_d;
    logic                     img_we;
    logic [DIGITS-1:0][7:0]   img_q, img_new;
    logic [NP*4-1:0]          bcd_pad;
    logic [NP-1:0]            nz_v;
    logic                     ovf;
    logic [PW-1:0]            presc_q, presc_d;
    logic [IW-1:0]            idx_q, idx_d;
    logic [DIGITS-1:0]        an_q, an_d;
    logic [7:0]               seg_q, seg_d;
`ifdef SEG_BLINK_EN
    logic [5:0]               wcnt_q, wcnt_d;
    logic                     phase_q, phase_d;
    logic                     frame_wrap;
`endif

    function automatic logic [7:0] glyph(input logic [3:0] d);
        case (d)
            4'd0:    glyph = 8'hC0;
            4'd1:    glyph = 8'hF9;
            4'd2:    glyph = 8'hA4;
            4'd3:    glyph = 8'hB0;
            4'd4:    glyph = 8'h99;
            4'd5:    glyph = 8'h92;
            4'd6:    glyph = 8'h82;
            4'd7:    glyph = 8'hF8;
            4'd8:    glyph = 8'h80;
            4'd9:    glyph = 8'h90;
            default: glyph = 8'hFF;
        endcase
    endfunction

    // Conversion FSM: capture on load, VAL_W shift-and-add steps, then commit.
    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        lbl_d   = lbl_q;
        img_we  = 1'b0;
        bcd_adj = bcd_q;
        for (int i = 0; i < BCD_D; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
        end
        case (state_q)
            S_IDLE: begin
                if (load) begin
                    sh_d    = value;
                    lbl_d   = label_en;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = S_CONV;
                end
            end
            S_CONV: begin
                // The adjusted top bit falls off; the BCD width always holds VAL_W bits.
                bcd_d = BW'({bcd_adj, sh_q[VAL_W-1]});
                sh_d  = {sh_q[VAL_W-2:0], 1'b0};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_MAX) state_d = S_COMMIT;
            end
            S_COMMIT: begin
                img_we  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Image builder: blanking, overflow 'E' fill and label from the final BCD.
    always_comb begin
        int nv;
        logic run;
        nv      = lbl_q ? DIGITS - 2 : DIGITS;
        bcd_pad = '0;
        bcd_pad[BW-1:0] = bcd_q;
        ovf = 1'b0;
        run = 1'b0;
        nz_v = '0;
        for (int i = NP - 1; i >= 0; i--) begin
            run = run | (bcd_pad[i*4 +: 4] != 4'd0);
            nz_v[i] = run;
            if (i >= nv && bcd_pad[i*4 +: 4] != 4'd0) ovf = 1'b1;
        end
        img_new = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (i < nv) begin
                if (ovf)                  img_new[i] = 8'h86;
                else if (nz_v[i] || i == 0) img_new[i] = glyph(bcd_pad[i*4 +: 4]);
            end else if (i == DIGITS - 1) begin
                img_new[i] = 8'hC7;
            end else begin
                img_new[i] = 8'hBF;
            end
        end
    end

    // Scan: prescaler, digit index and registered pin drive.
    always_comb begin
        presc_d = presc_q + 1'b1;
        idx_d   = idx_q;
        if (presc_q == PRESC_MAX) begin
            presc_d = '0;
            idx_d   = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
        end
        an_d  = ~(DIGITS'(1) << idx_q);
        seg_d = img_q[idx_q];
`ifdef SEG_BLINK_EN
        frame_wrap = (presc_q == PRESC_MAX) && (idx_q == IDX_MAX);
        wcnt_d     = wcnt_q + {5'd0, frame_wrap};
        phase_d    = phase_q ^ (frame_wrap && wcnt_q == 6'd63);
        if (blink && phase_q) an_d = '1;
`endif
    end

    // State registers for conversion, image and scan.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            sh_q    <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            lbl_q   <= 1'b0;
            img_q   <= RST_IMG;
            presc_q <= '0;
            idx_q   <= '0;
            an_q    <= '1;
            seg_q   <= 8'hFF;
`ifdef SEG_BLINK_EN
            wcnt_q  <= '0;
            phase_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            lbl_q   <= lbl_d;
            if (img_we) img_q <= img_new;
            presc_q <= presc_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
`ifdef SEG_BLINK_EN
            wcnt_q  <= wcnt_d;
            phase_q <= phase_d;
`endif
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign AN          = an_q;
    assign SEGMENT     = seg_q;
    assign dbg_state_o = state_q;

endmodule
